// File: rtl/updown_ctrl.sv
// Push-button front end for the up/down counter: sync, debounce, arbitration, registered strobe.
// Optional auto-repeat while a single button is held is enabled by `define AUTOREPEAT_EN.
module updown_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 20,
  parameter int unsigned REPEAT_PERIOD   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  output logic enable,
  output logic up_down
);

  typedef enum logic [1:0] {IDLE, UP_HELD, DOWN_HELD, LOCK} state_t;

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("updown_ctrl: DEBOUNCE_CYCLES must be >= 2 and REPEAT_* >= 1");
  end

  // bit 0 = up button, bit 1 = down button
  logic [1:0]    raw, sync_a, sync_b, level;
  logic [CW-1:0] db_cnt [2];
  logic          u, d;

  state_t state, state_nxt;
  logic   pulse, dir_nxt, rpt_pulse;

  assign raw = {btn_down, btn_up};
  assign u   = level[0];
  assign d   = level[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
      level  <= '0;
      for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync_b[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          level[i]  <= sync_b[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  // In IDLE both levels were low on entry, so a high level here is a fresh press.
  always_comb begin
    state_nxt = state;
    pulse     = 1'b0;
    dir_nxt   = up_down;
    case (state)
      IDLE: begin
        if (u && !d) begin
          pulse     = 1'b1;
          dir_nxt   = 1'b1;
          state_nxt = UP_HELD;
        end else if (d && !u) begin
          pulse     = 1'b1;
          dir_nxt   = 1'b0;
          state_nxt = DOWN_HELD;
        end else if (u && d) begin
          state_nxt = LOCK;
        end
      end
      UP_HELD: begin
        if (!u && !d)  state_nxt = IDLE;
        else if (d)    state_nxt = LOCK;
      end
      DOWN_HELD: begin
        if (!u && !d)  state_nxt = IDLE;
        else if (u)    state_nxt = LOCK;
      end
      LOCK: begin
        if (!u && !d)  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TW      = (RPT_MAX > 1) ? $clog2(RPT_MAX + 1) : 1;
  localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

  logic [TW-1:0] rpt_timer, rpt_timer_nxt;
  logic          rpt_armed, rpt_armed_nxt;

  // rpt_armed selects the period after the first (delayed) repeat has fired.
  always_comb begin
    rpt_timer_nxt = '0;
    rpt_armed_nxt = 1'b0;
    rpt_pulse     = 1'b0;
    if ((state == UP_HELD && u && !d) || (state == DOWN_HELD && d && !u)) begin
      if (rpt_timer == (rpt_armed ? PERIOD_LAST : DELAY_LAST)) begin
        rpt_pulse     = 1'b1;
        rpt_armed_nxt = 1'b1;
      end else begin
        rpt_timer_nxt = rpt_timer + TW'(1);
        rpt_armed_nxt = rpt_armed;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_timer <= '0;
      rpt_armed <= 1'b0;
    end else begin
      rpt_timer <= rpt_timer_nxt;
      rpt_armed <= rpt_armed_nxt;
    end
  end
`else
  assign rpt_pulse = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      enable  <= 1'b0;
      up_down <= 1'b1;
    end else begin
      state   <= state_nxt;
      enable  <= pulse | rpt_pulse;
      up_down <= dir_nxt;
    end
  end

endmodule

// File: tb/tb_updown_ctrl.sv
// Randomized self-checking bench for updown_ctrl against a behavioural press/hold model.
// Build with or without `define AUTOREPEAT_EN; the model follows the same macro.
module tb_updown_ctrl;

  localparam int DC     = 4;
  localparam int DELAY  = 20;
  localparam int PERIOD = 8;

  logic clk = 1'b0;
  logic rst, btn_up, btn_down;
  logic enable, up_down;

  int n_checks = 0;
  int n_errors = 0;

  updown_ctrl #(.DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
    .enable(enable), .up_down(up_down)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: raw seen by the debouncer two edges late; a level is accepted once the
  // last DC samples since the previous acceptance all disagree with it.
  logic [1:0]    m_dly0, m_dly1, m_level;
  logic [DC-1:0] m_hist [2];
  int            m_fill [2];
  int            owner;     // 0 none, 1 up, 2 down, 3 locked
  longint        cyc, next_rep;
  logic          exp_en, exp_ud;

  task automatic model_step(input logic u, input logic d, input logic r);
    logic lu, ld, s;
    cyc++;
    if (r) begin
      m_dly0 = '0; m_dly1 = '0; m_level = '0;
      for (int b = 0; b < 2; b++) begin m_hist[b] = '0; m_fill[b] = 0; end
      owner = 0; exp_en = 1'b0; exp_ud = 1'b1;
      return;
    end
    lu = m_level[0];
    ld = m_level[1];
    exp_en = 1'b0;
    case (owner)
      0: begin
        if (lu && !ld)      begin exp_en = 1; exp_ud = 1; owner = 1; next_rep = cyc + DELAY; end
        else if (ld && !lu) begin exp_en = 1; exp_ud = 0; owner = 2; next_rep = cyc + DELAY; end
        else if (lu && ld)  owner = 3;
      end
      1, 2: begin
        if (!lu && !ld) owner = 0;
        else if ((owner == 1 && ld) || (owner == 2 && lu)) owner = 3;
`ifdef AUTOREPEAT_EN
        else if (cyc == next_rep) begin exp_en = 1; next_rep = cyc + PERIOD; end
`endif
      end
      default: if (!lu && !ld) owner = 0;
    endcase
    for (int b = 0; b < 2; b++) begin
      s = m_dly1[b];
      m_hist[b] = {m_hist[b][DC-2:0], s};
      if (m_fill[b] < DC) m_fill[b]++;
      if (m_fill[b] == DC && m_hist[b] == {DC{~m_level[b]}}) begin
        m_level[b] = s;
        m_fill[b]  = 0;
      end
    end
    m_dly1 = m_dly0;
    m_dly0 = {d, u};
  endtask

  task automatic step(input logic u, input logic d, input logic r);
    btn_up = u; btn_down = d; rst = r;
    @(posedge clk);
    model_step(u, d, r);
    #1;
    check_val("enable", enable, exp_en);
    check_val("up_down", up_down, exp_ud);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic hold(input logic u, input logic d, input int n);
    for (int i = 0; i < n; i++) step(u, d, 0);
  endtask

  // Counts edges from the first one that samples the press until enable is seen.
  task automatic measure_latency(input logic u, input logic d, input string tag);
    int n;
    n = 0;
    do begin
      step(u, d, 0);
      n++;
    end while (enable !== 1'b1 && n < 20);
    check_val(tag, n, 3 + DC);
  endtask

  initial begin
    btn_up = 0; btn_down = 0; rst = 1;
    cyc = 0; next_rep = 0; owner = 0;
    m_dly0 = '0; m_dly1 = '0; m_level = '0;
    exp_en = 0; exp_ud = 1;
    for (int b = 0; b < 2; b++) begin m_hist[b] = '0; m_fill[b] = 0; end

    // Reset with btn_up held, then press accepted after full latency
    step(1, 0, 1);
    step(1, 0, 1);
    measure_latency(1, 0, "rst_press_latency");
    hold(1, 0, 5);
    idle(12);

    // Glitch shorter than the debounce window
    hold(1, 0, 3);
    idle(12);

    // Plain up press, 30 cycles
    measure_latency(1, 0, "up_latency");
    check_val("up_dir", up_down, 1);
    hold(1, 0, 23);
    idle(12);

    // Down press, then up joins while held
    measure_latency(0, 1, "down_latency");
    check_val("down_dir", up_down, 0);
    hold(0, 1, 5);
    hold(1, 1, 15);
    idle(12);

    // Both raised together from idle
    hold(1, 1, 15);
    hold(1, 0, 3);
    idle(12);

    // Long up hold for repeat behaviour
    measure_latency(1, 0, "long_up_latency");
    hold(1, 0, 53);
    idle(12);

    // Reset in the middle of a down hold
    measure_latency(0, 1, "pre_rst_latency");
    hold(0, 1, 3);
    step(0, 1, 1);
    check_val("midrst_dir", up_down, 1);
    measure_latency(0, 1, "mid_rst_latency");
    hold(0, 1, 4);
    idle(12);

    // Randomized press/release/glitch/reset traffic
    for (int seg = 0; seg < 160; seg++) begin
      int mode;
      mode = $urandom_range(0, 9);
      if (mode == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 2)); k++)
          step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
      end else if (mode <= 2) begin
        hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, DC - 1));
      end else begin
        hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 40));
      end
    end
    idle(12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
